// File: rtl/relogio_pkg.sv
// Shared types, digit moduli and display helpers for the synchronous BCD clock.
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  localparam int unsigned MOD_US = 10;
  localparam int unsigned MOD_DS = 6;
  localparam int unsigned MOD_UM = 10;
  localparam int unsigned MOD_DM = 6;

  // Active-high {g,f,e,d,c,b,a}; codes above 9 render blank.
  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // 24 h BCD hour to {pm, 12 h BCD hour}; 0 and 12 both show as 12.
  function automatic logic [8:0] hour12(input logic [7:0] bcd_h);
    logic [4:0] h;
    logic [4:0] h12;
    logic       pm_f;
    logic [3:0] tens;
    logic [3:0] units;
    h = 5'(bcd_h[7:4]) * 5'd10 + 5'(bcd_h[3:0]);
    pm_f = (h >= 5'd12);
    if (h == 5'd0)      h12 = 5'd12;
    else if (h > 5'd12) h12 = h - 5'd12;
    else                h12 = h;
    if (h12 >= 5'd10) begin
      tens  = 4'd1;
      units = 4'(h12 - 5'd10);
    end else begin
      tens  = 4'd0;
      units = 4'(h12);
    end
    return {pm_f, tens, units};
  endfunction

endpackage

// File: rtl/relogio_bcd_sincrono_bcd_digit.sv
// One BCD digit counter with a combinational carry enable for the next digit.
module bcd_digit #(
  parameter int unsigned MODULO = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] r_q;

  assign carry = en & (r_q == 4'(MODULO - 1));
  assign q     = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_q <= '0;
    else if (clr)    r_q <= '0;
    else if (en)     r_q <= carry ? '0 : r_q + 4'd1;
  end

endmodule

// File: rtl/relogio_bcd_sincrono.sv
// Single-clock HH:MM:SS BCD clock with set mode, edit blinking, 12/24 h display.
module relogio_bcd_sincrono
  import relogio_pkg::*;
#(
  parameter int unsigned MAIN_CLOCK     = 10_000_000,
  parameter int unsigned FAST_HZ        = 500,
  parameter int unsigned MODE_12H       = 0,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        speed,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [7:0]  dh,
  output logic [7:0]  uh,
  output logic [7:0]  dm,
  output logic [7:0]  um,
  output logic [7:0]  ds,
  output logic [7:0]  us,
  output logic [23:0] bcd_time,
  output logic        pm,
  output logic        tick
);

  localparam int unsigned FAST_DIV = MAIN_CLOCK / FAST_HZ;
  localparam int unsigned PW = (MAIN_CLOCK > 1) ? $clog2(MAIN_CLOCK) : 1;
  localparam int unsigned FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;

  logic [PW-1:0] r_phase;
  logic [FW-1:0] r_fast;
  logic          r_mode_q;
  logic          r_inc_q;
  logic [3:0]    r_dh;
  logic [3:0]    r_uh;
  state_t        r_state;
  state_t        w_next_state;

  logic       w_phase_end, w_fast_end, w_dot_on;
  logic       w_mode_p, w_inc_p, w_inc_m, w_hour_inc, w_clr_sec;
  logic [3:0] w_us, w_ds, w_um, w_dm;
  logic       w_us_c, w_ds_c, w_um_c, w_dm_c;

  assign w_phase_end = (r_phase == PW'(MAIN_CLOCK - 1));
  assign w_fast_end  = (r_fast == FW'(FAST_DIV - 1));
  assign w_dot_on    = (r_phase < PW'(MAIN_CLOCK / 2));

  // Mode beats inc when both edges land on the same cycle.
  assign w_mode_p = btn_mode & ~r_mode_q;
  assign w_inc_p  = btn_inc & ~r_inc_q & ~w_mode_p;

  assign tick = (r_state == RUN) & (speed ? w_phase_end : w_fast_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= '0;
      r_mode_q <= 1'b0;
      r_inc_q  <= 1'b0;
    end else begin
      r_phase  <= w_phase_end ? '0 : r_phase + PW'(1);
      r_mode_q <= btn_mode;
      r_inc_q  <= btn_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_fast <= '0;
    else if (r_state != RUN)  r_fast <= '0;
    else                      r_fast <= w_fast_end ? '0 : r_fast + FW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_clr_sec    = 1'b0;
    if (w_mode_p) begin
      case (r_state)
        RUN:     w_next_state = SET_H;
        SET_H:   w_next_state = SET_M;
        SET_M: begin
          w_next_state = RUN;
          w_clr_sec    = 1'b1;
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  // Minute edits reuse the um/dm chain; the dm carry is kept out of hours outside RUN.
  assign w_inc_m    = (r_state == SET_M) & w_inc_p;
  assign w_hour_inc = (w_dm_c & (r_state == RUN)) | ((r_state == SET_H) & w_inc_p);

  bcd_digit #(.MODULO(MOD_US)) u_us (
    .clk(clk), .rst(rst), .en(tick), .clr(w_clr_sec), .q(w_us), .carry(w_us_c)
  );
  bcd_digit #(.MODULO(MOD_DS)) u_ds (
    .clk(clk), .rst(rst), .en(w_us_c), .clr(w_clr_sec), .q(w_ds), .carry(w_ds_c)
  );
  bcd_digit #(.MODULO(MOD_UM)) u_um (
    .clk(clk), .rst(rst), .en(w_ds_c | w_inc_m), .clr(1'b0), .q(w_um), .carry(w_um_c)
  );
  bcd_digit #(.MODULO(MOD_DM)) u_dm (
    .clk(clk), .rst(rst), .en(w_um_c), .clr(1'b0), .q(w_dm), .carry(w_dm_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dh <= '0;
      r_uh <= '0;
    end else if (w_hour_inc) begin
      if (r_dh == 4'd2 && r_uh == 4'd3) begin
        r_dh <= '0;
        r_uh <= '0;
      end else if (r_uh == 4'd9) begin
        r_uh <= '0;
        r_dh <= r_dh + 4'd1;
      end else begin
        r_uh <= r_uh + 4'd1;
      end
    end
  end

  assign bcd_time = {r_dh, r_uh, w_dm, w_um, w_ds, w_us};

  logic [8:0] w_h12;
  logic [3:0] w_disp_dh, w_disp_uh;
  logic       w_blank_h, w_blank_m, w_dp_on;

  assign w_h12     = hour12({r_dh, r_uh});
  assign w_disp_dh = (MODE_12H != 0) ? w_h12[7:4] : r_dh;
  assign w_disp_uh = (MODE_12H != 0) ? w_h12[3:0] : r_uh;
  assign pm        = (MODE_12H != 0) & w_h12[8];
  assign w_blank_h = (r_state == SET_H) & ~w_dot_on;
  assign w_blank_m = (r_state == SET_M) & ~w_dot_on;
  assign w_dp_on   = (r_state == RUN) ? w_dot_on : 1'b1;

  function automatic logic [7:0] seg_out(input logic [3:0] bcd, input logic dp,
                                         input logic blank);
    logic [7:0] raw;
    raw = blank ? 8'h00 : {dp, seg7(bcd)};
    return (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
  endfunction

  assign dh = seg_out(w_disp_dh, 1'b0, w_blank_h);
  assign uh = seg_out(w_disp_uh, w_dp_on, w_blank_h);
  assign dm = seg_out(w_dm, 1'b0, w_blank_m);
  assign um = seg_out(w_um, w_dp_on, w_blank_m);
  assign ds = seg_out(w_ds, 1'b0, 1'b0);
  assign us = seg_out(w_us, 1'b0, 1'b0);

endmodule

// File: tb/tb_relogio_bcd_sincrono.sv
// Self-checking bench: table-driven runs, hand sequences and a random run vs a time-of-day model.
module tb_relogio_bcd_sincrono;

  localparam int unsigned MC  = 20;
  localparam int unsigned FHZ = 10;
  localparam int unsigned FD  = MC / FHZ;

  logic clk = 1'b0;
  logic rst, speed, btn_mode, btn_inc;
  logic [7:0]  dh, uh, dm, um, ds, us;
  logic [23:0] bcd_time;
  logic        pm, tick;
  logic [7:0]  dh12, uh12, dm12, um12, ds12, us12;
  logic [23:0] bcd12;
  logic        pm12, tick12;

  relogio_bcd_sincrono #(.MAIN_CLOCK(MC), .FAST_HZ(FHZ), .MODE_12H(0), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .speed(speed), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .dh(dh), .uh(uh), .dm(dm), .um(um), .ds(ds), .us(us),
    .bcd_time(bcd_time), .pm(pm), .tick(tick)
  );

  relogio_bcd_sincrono #(.MAIN_CLOCK(MC), .FAST_HZ(FHZ), .MODE_12H(1), .SEG_ACTIVE_LOW(1)) dut12 (
    .clk(clk), .rst(rst), .speed(speed), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .dh(dh12), .uh(uh12), .dm(dm12), .um(um12), .ds(ds12), .us(us12),
    .bcd_time(bcd12), .pm(pm12), .tick(tick12)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int tick_cnt = 0;

  // Reference model: time of day plus button/phase bookkeeping (state 0 run, 1 set h, 2 set m).
  int m_h, m_m, m_s, m_state, m_phase, m_fast;
  bit m_pmode, m_pinc;

  logic [6:0] SEGT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    bit          sp;
    int          cycles;
    logic [23:0] bcd;
    int          ticks;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [7:0] eseg(int d, bit dp, bit blank);
    logic [7:0] r;
    r = blank ? 8'h00 : {dp, SEGT[d]};
    return ~r;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_tick();
    return (m_state == 0) && (speed ? (m_phase == MC - 1) : (m_fast == FD - 1));
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_state = 0; m_phase = 0; m_fast = 0;
    m_pmode = 0; m_pinc = 0;
  endtask

  task automatic check_model();
    bit dot, bh, bm, dpon;
    int h12;
    logic [23:0] eb;
    dot  = (m_phase < MC / 2);
    bh   = (m_state == 1) && !dot;
    bm   = (m_state == 2) && !dot;
    dpon = (m_state == 0) ? dot : 1'b1;
    h12  = (m_h % 12 == 0) ? 12 : m_h % 12;
    eb   = {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), 4'(m_s / 10), 4'(m_s % 10)};
    cmp("bcd_time", 64'(bcd_time), 64'(eb));
    cmp("tick", 64'(tick), 64'(exp_tick()));
    cmp("seg_hhmm", 64'({dh, uh, dm, um}),
        64'({eseg(m_h / 10, 0, bh), eseg(m_h % 10, dpon, bh), eseg(m_m / 10, 0, bm), eseg(m_m % 10, dpon, bm)}));
    cmp("seg_ss", 64'({ds, us}), 64'({eseg(m_s / 10, 0, 0), eseg(m_s % 10, 0, 0)}));
    cmp("pm_24h", 64'(pm), 64'(0));
    cmp("seg12_hh", 64'({dh12, uh12}), 64'({eseg(h12 / 10, 0, bh), eseg(h12 % 10, dpon, bh)}));
    cmp("pm_12h", 64'(pm12), 64'(m_h >= 12));
  endtask

  task automatic model_edge();
    bit mp, ip, tk;
    int tod;
    mp = btn_mode && !m_pmode;
    ip = btn_inc && !m_pinc && !mp;
    tk = exp_tick();
    if (tk) begin
      tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = tod / 3600;
      m_m = (tod / 60) % 60;
      m_s = tod % 60;
    end
    if (m_state == 1 && ip) m_h = (m_h + 1) % 24;
    if (m_state == 2 && ip) m_m = (m_m + 1) % 60;
    m_fast = (m_state != 0) ? 0 : (m_fast + 1) % FD;
    if (mp) begin
      if (m_state == 2) m_s = 0;
      m_state = (m_state + 1) % 3;
    end
    m_phase = (m_phase + 1) % MC;
    m_pmode = btn_mode;
    m_pinc  = btn_inc;
  endtask

  // Entered and left at a falling edge.
  task automatic step(input bit sp, input bit md, input bit in);
    speed = sp; btn_mode = md; btn_inc = in;
    #1;
    check_model();
    if (tick === 1'b1) tick_cnt++;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input bit sp, input bit md, input bit in);
    step(sp, md, in);
    step(sp, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick_cnt = 0;
  endtask

  initial begin
    tbl[0] = '{sp: 1'b1, cycles: 20, bcd: 24'h000001, ticks: 1};
    tbl[1] = '{sp: 1'b0, cycles: 40, bcd: 24'h000020, ticks: 20};
    tbl[2] = '{sp: 1'b1, cycles: 19, bcd: 24'h000000, ticks: 0};
    tbl[3] = '{sp: 1'b0, cycles: 1,  bcd: 24'h000000, ticks: 0};
    tbl[4] = '{sp: 1'b0, cycles: 2,  bcd: 24'h000001, ticks: 1};
    tbl[5] = '{sp: 1'b1, cycles: 40, bcd: 24'h000002, ticks: 2};

    rst = 1'b1; speed = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    @(negedge clk);
    do_reset();
    cmp("reset_segs", 64'({dh, uh, dm, um, ds, us}), 64'h0000_C040_C040_C0C0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].sp, 1'b0, 1'b0);
      cmp($sformatf("tbl%0d_bcd", i), 64'(bcd_time), 64'(tbl[i].bcd));
      cmp($sformatf("tbl%0d_ticks", i), 64'(tick_cnt), 64'(tbl[i].ticks));
    end

    // Fast run then switch to 1 Hz without reset: 20 s after 40 cycles, next tick at phase 19.
    do_reset();
    for (int c = 0; c < 40; c++) step(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 1'b0);
    cmp("speed_switch", 64'(bcd_time), 64'h000021);

    // 23:59:59 rollover.
    do_reset();
    press(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 23; k++) press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    cmp("preload_2359", 64'(bcd_time), 64'h235900);
    for (int c = 0; c < 118; c++) step(1'b0, 1'b0, 1'b0);
    cmp("at_235959", 64'(bcd_time), 64'h235959);
    tick_cnt = 0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cmp("wrap_000000", 64'(bcd_time), 64'h000000);
    cmp("wrap_ticks", 64'(tick_cnt), 64'(1));
    cmp("wrap_pm", 64'(pm), 64'(0));

    // Set 01:01:00 with wraparound presses, check blanking in SET_H.
    do_reset();
    press(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) press(1'b1, 1'b0, 1'b1);
    cmp("seth_hours01", 64'(bcd_time[23:16]), 64'h01);
    for (int k = 0; k < MC && m_phase != 15; k++) step(1'b1, 1'b0, 1'b0);
    cmp("seth_blank", 64'({dh, uh}), 64'hFFFF);
    press(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 61; k++) press(1'b1, 1'b0, 1'b1);
    cmp("setm_min01", 64'(bcd_time[23:8]), 64'h0101);
    press(1'b1, 1'b1, 1'b0);
    cmp("set_010100", 64'(bcd_time), 64'h010100);

    // Simultaneous mode+inc in SET_H, then async reset inside SET_M.
    do_reset();
    press(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 1'b1);
    press(1'b1, 1'b1, 1'b1);
    cmp("both_hours", 64'(bcd_time[23:16]), 64'h03);
    press(1'b1, 1'b0, 1'b1);
    cmp("both_in_setm", 64'(bcd_time[23:8]), 64'h0301);
    rst = 1'b1;
    #1;
    cmp("async_rst_bcd", 64'(bcd_time), 64'h000000);
    cmp("async_rst_segs", 64'({dh, uh, dm, um, ds, us}), 64'h0000_C040_C040_C0C0);
    do_reset();
    press(1'b1, 1'b0, 1'b1);
    cmp("run_inc_ignored", 64'(bcd_time), 64'h000000);

    // 12 h display.
    do_reset();
    press(1'b1, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) press(1'b1, 1'b0, 1'b1);
    press(1'b1, 1'b1, 1'b0);
    cmp("t0030_bcd", 64'(bcd12), 64'h003000);
    cmp("t0030_disp12", 64'({dh12[6:0], uh12[6:0]}), 64'({7'h79, 7'h24}));
    cmp("t0030_pm", 64'(pm12), 64'(0));
    press(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 13; k++) press(1'b1, 1'b0, 1'b1);
    press(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 35; k++) press(1'b1, 1'b0, 1'b1);
    press(1'b1, 1'b1, 1'b0);
    cmp("t1305_bcd", 64'(bcd12), 64'h130500);
    cmp("t1305_disp12", 64'({dh12[6:0], uh12[6:0]}), 64'({7'h40, 7'h79}));
    cmp("t1305_pm", 64'(pm12), 64'(1));

    // Random buttons and speed against the model.
    do_reset();
    begin
      bit sp, md, in;
      sp = 1'b0; md = 1'b0; in = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 49) == 0) sp = ~sp;
        if ($urandom_range(0, 29) == 0) md = ~md;
        if ($urandom_range(0, 3) == 0)  in = ~in;
        step(sp, md, in);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
